entry_sequencer: RTL and testbench

Front-end controller for `unlocker`. It collects 4-bit digits into the four username slots and four password slots, and drives `inputCount`. It clears the buffers when `unlocker` consumes them. It sequences failed-login handling: a timed error display for one failure, a timed lockout after three failures, then the `flagResolve` handshake. It sits between the debounced button/switch front end and `unlocker`, and is the only driver of `unlocker`'s credential inputs.

---
 rtl/entry_sequencer_pkg.sv | 17 +
 rtl/entry_sequencer_hold_timer.sv | 37 +++
 rtl/entry_sequencer.sv | 145 ++++++++++++++
 tb/tb_entry_sequencer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/entry_sequencer_pkg.sv
// Shared types and sizing for the credential entry front end.
package entry_pkg;

  typedef enum logic [2:0] {
    ENTRY,
    FULL,
    SHOW,
    LOCK,
    RESOLVE
  } state_e;

  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned SLOT_COUNT = 8;
  localparam int unsigned NAME_SLOTS = 4;
  localparam int unsigned COUNT_W    = 4;

endpackage

// File: rtl/entry_sequencer_hold_timer.sv
// Up-counter that restarts from zero on start and flags its terminal count.
module hold_timer #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             en,
  input  logic [CNT_W-1:0] term,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Terminal count is reached while enabled; exit happens on the following edge.
  assign done = en && (cnt_q == term);

  // Next count: restart on start, otherwise advance until terminal.
  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = '0;
    end else if (en && !done) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/entry_sequencer.sv
// Collects digits into username/password slots and sequences failed-login
// error display, lockout and the flagResolve handshake with unlocker.
module entry_sequencer
  import entry_pkg::*;
#(
  parameter int unsigned FLAG_HOLD_CYCLES = 50_000_000,
  parameter int unsigned LOCKOUT_CYCLES   = 500_000_000,
  parameter int unsigned CNT_W            = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               digit_valid,
  input  logic [DIGIT_W-1:0] digit,
  input  logic               backspace,
  input  logic               clear,
  input  logic               resetCount,
  input  logic               flag,
  input  logic               flagSelect,
  output logic [COUNT_W-1:0] inputCount,
  output logic [DIGIT_W-1:0] userNameInput0,
  output logic [DIGIT_W-1:0] userNameInput1,
  output logic [DIGIT_W-1:0] userNameInput2,
  output logic [DIGIT_W-1:0] userNameInput3,
  output logic [DIGIT_W-1:0] passwordInput0,
  output logic [DIGIT_W-1:0] passwordInput1,
  output logic [DIGIT_W-1:0] passwordInput2,
  output logic [DIGIT_W-1:0] passwordInput3,
  output logic               flagResolve,
  output logic               errorInd,
  output logic               lockoutInd
);

  localparam logic [COUNT_W-1:0] FULL_COUNT = COUNT_W'(SLOT_COUNT);
  localparam logic [CNT_W-1:0]   HOLD_TERM  = CNT_W'(FLAG_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   LOCK_TERM  = CNT_W'(LOCKOUT_CYCLES - 1);

  state_e                                  state_q, state_d;
  logic [COUNT_W-1:0]                      count_q, count_d;
  logic [SLOT_COUNT-1:0][DIGIT_W-1:0]      slots_q, slots_d;
  logic                                    rc_q;
  logic                                    resolve_q, resolve_d;
  logic                                    err_q, err_d;
  logic                                    lock_q, lock_d;
  logic                                    rc_edge;
  logic                                    tmr_start, tmr_en, tmr_done;
  logic [CNT_W-1:0]                        tmr_term;

  assign rc_edge   = resetCount && !rc_q;
  assign tmr_start = (state_d != state_q);
  assign tmr_en    = (state_q == SHOW) || (state_q == LOCK);
  assign tmr_term  = (state_q == LOCK) ? LOCK_TERM : HOLD_TERM;

  hold_timer #(
    .CNT_W (CNT_W)
  ) u_hold_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .start (tmr_start),
    .en    (tmr_en),
    .term  (tmr_term),
    .done  (tmr_done)
  );

  // Next state, slot contents and count; events resolved in priority order.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    slots_d = slots_q;
    unique case (state_q)
      ENTRY, FULL: begin
        if (flag) begin
          state_d = flagSelect ? LOCK : SHOW;
          count_d = '0;
          slots_d = '0;
        end else if (rc_edge || clear) begin
          state_d = ENTRY;
          count_d = '0;
          slots_d = '0;
        end else if (backspace) begin
          if (count_q != '0) begin
            count_d               = count_q - COUNT_W'(1);
            slots_d[count_d[2:0]] = '0;
            state_d               = ENTRY;
          end
        end else if (digit_valid && (count_q < FULL_COUNT)) begin
          slots_d[count_q[2:0]] = digit;
          count_d               = count_q + COUNT_W'(1);
          if (count_d == FULL_COUNT) begin
            state_d = FULL;
          end
        end
      end
      SHOW, LOCK: begin
        if (tmr_done) begin
          state_d = RESOLVE;
        end
      end
      RESOLVE: begin
        if (!flag) begin
          state_d = ENTRY;
        end
      end
      default: state_d = ENTRY;
    endcase
    // Indicators are registered copies of the state being entered.
    resolve_d = (state_d == RESOLVE);
    err_d     = (state_d == SHOW);
    lock_d    = (state_d == LOCK);
  end

  // State, buffers, indicators and resetCount edge register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ENTRY;
      count_q   <= '0;
      slots_q   <= '0;
      rc_q      <= 1'b0;
      resolve_q <= 1'b0;
      err_q     <= 1'b0;
      lock_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      slots_q   <= slots_d;
      rc_q      <= resetCount;
      resolve_q <= resolve_d;
      err_q     <= err_d;
      lock_q    <= lock_d;
    end
  end

  assign inputCount     = count_q;
  assign userNameInput0 = slots_q[0];
  assign userNameInput1 = slots_q[1];
  assign userNameInput2 = slots_q[2];
  assign userNameInput3 = slots_q[3];
  assign passwordInput0 = slots_q[NAME_SLOTS + 0];
  assign passwordInput1 = slots_q[NAME_SLOTS + 1];
  assign passwordInput2 = slots_q[NAME_SLOTS + 2];
  assign passwordInput3 = slots_q[NAME_SLOTS + 3];
  assign flagResolve    = resolve_q;
  assign errorInd       = err_q;
  assign lockoutInd     = lock_q;

endmodule

// File: tb/tb_entry_sequencer.sv
// Directed bench for entry_sequencer with short hold/lockout times.
module tb_entry_sequencer;

  logic       clk;
  logic       rst_n;
  logic       digit_valid;
  logic [3:0] digit;
  logic       backspace;
  logic       clear;
  logic       resetCount;
  logic       flag;
  logic       flagSelect;
  logic [3:0] inputCount;
  logic [3:0] un0, un1, un2, un3, pw0, pw1, pw2, pw3;
  logic       flagResolve, errorInd, lockoutInd;
  logic [3:0] slot [8];

  int checks   = 0;
  int failures = 0;

  entry_sequencer #(
    .FLAG_HOLD_CYCLES (5),
    .LOCKOUT_CYCLES   (10),
    .CNT_W            (8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .digit_valid    (digit_valid),
    .digit          (digit),
    .backspace      (backspace),
    .clear          (clear),
    .resetCount     (resetCount),
    .flag           (flag),
    .flagSelect     (flagSelect),
    .inputCount     (inputCount),
    .userNameInput0 (un0),
    .userNameInput1 (un1),
    .userNameInput2 (un2),
    .userNameInput3 (un3),
    .passwordInput0 (pw0),
    .passwordInput1 (pw1),
    .passwordInput2 (pw2),
    .passwordInput3 (pw3),
    .flagResolve    (flagResolve),
    .errorInd       (errorInd),
    .lockoutInd     (lockoutInd)
  );

  assign slot[0] = un0;
  assign slot[1] = un1;
  assign slot[2] = un2;
  assign slot[3] = un3;
  assign slot[4] = pw0;
  assign slot[5] = pw1;
  assign slot[6] = pw2;
  assign slot[7] = pw3;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; sample/drive 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enter_digit(input logic [3:0] d);
    digit_valid = 1'b1;
    digit       = d;
    tick();
    digit_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    checks++;
    if (inputCount !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", inputCount); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (slot[i] !== 4'd0) begin failures++; $display("FAIL reset_slot%0d got=%0d exp=0", i, slot[i]); end
    end
    checks++;
    if ({flagResolve, errorInd, lockoutInd} !== 3'b000) begin
      failures++; $display("FAIL reset_ind got=%b exp=000", {flagResolve, errorInd, lockoutInd});
    end
  endtask

  task automatic test_fill();
    logic [3:0] exp [8];
    for (int i = 0; i < 8; i++) begin
      enter_digit(4'(i + 1));
      checks++;
      if (inputCount !== 4'(i + 1)) begin failures++; $display("FAIL fill_count got=%0d exp=%0d", inputCount, i + 1); end
    end
    enter_digit(4'd9);
    for (int i = 0; i < 8; i++) exp[i] = 4'(i + 1);
    checks++;
    if (inputCount !== 4'd8) begin failures++; $display("FAIL fill_ninth_count got=%0d exp=8", inputCount); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (slot[i] !== exp[i]) begin failures++; $display("FAIL fill_slot%0d got=%0d exp=%0d", i, slot[i], exp[i]); end
    end
    // Backspace out of FULL, then a digit is accepted again
    backspace = 1'b1; tick(); backspace = 1'b0;
    checks++;
    if (inputCount !== 4'd7 || pw3 !== 4'd0) begin
      failures++; $display("FAIL full_backspace got=%0d/%0d exp=7/0", inputCount, pw3);
    end
    enter_digit(4'd9);
    checks++;
    if (inputCount !== 4'd8 || pw3 !== 4'd9) begin
      failures++; $display("FAIL refill got=%0d/%0d exp=8/9", inputCount, pw3);
    end
    clear = 1'b1; tick(); clear = 1'b0;
    checks++;
    if (inputCount !== 4'd0 || un0 !== 4'd0 || pw3 !== 4'd0) begin
      failures++; $display("FAIL clear got=%0d/%0d/%0d exp=0/0/0", inputCount, un0, pw3);
    end
  endtask

  task automatic test_backspace();
    logic [3:0] exp_cnt [4];
    exp_cnt[0] = 4'd2; exp_cnt[1] = 4'd1; exp_cnt[2] = 4'd0; exp_cnt[3] = 4'd0;
    enter_digit(4'd3);
    enter_digit(4'd4);
    enter_digit(4'd5);
    for (int i = 0; i < 4; i++) begin
      backspace = 1'b1; tick(); backspace = 1'b0;
      checks++;
      if (inputCount !== exp_cnt[i]) begin failures++; $display("FAIL bs_count%0d got=%0d exp=%0d", i, inputCount, exp_cnt[i]); end
      checks++;
      if (i < 3 && slot[2 - i] !== 4'd0) begin failures++; $display("FAIL bs_slot%0d got=%0d exp=0", 2 - i, slot[2 - i]); end
    end
  endtask

  task automatic test_reset_count();
    for (int i = 0; i < 8; i++) enter_digit(4'(i + 1));
    resetCount = 1'b1;
    tick();
    checks++;
    if (inputCount !== 4'd0 || un0 !== 4'd0 || pw3 !== 4'd0) begin
      failures++; $display("FAIL rc_clear got=%0d/%0d/%0d exp=0/0/0", inputCount, un0, pw3);
    end
    enter_digit(4'd7);
    tick();
    checks++;
    if (inputCount !== 4'd1 || un0 !== 4'd7) begin
      failures++; $display("FAIL rc_level got=%0d/%0d exp=1/7", inputCount, un0);
    end
    resetCount = 1'b0;
    tick();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic test_show();
    enter_digit(4'd1);
    enter_digit(4'd2);
    flag = 1'b1; flagSelect = 1'b0;
    tick();
    checks++;
    if (inputCount !== 4'd0 || un0 !== 4'd0 || errorInd !== 1'b1) begin
      failures++; $display("FAIL show_entry got=%0d/%0d/%b exp=0/0/1", inputCount, un0, errorInd);
    end
    for (int i = 1; i < 5; i++) begin
      tick();
      checks++;
      if (errorInd !== 1'b1 || flagResolve !== 1'b0) begin
        failures++; $display("FAIL show_hold%0d got=%b%b exp=10", i, errorInd, flagResolve);
      end
    end
    tick();
    checks++;
    if (errorInd !== 1'b0 || flagResolve !== 1'b1) begin
      failures++; $display("FAIL show_resolve got=%b%b exp=01", errorInd, flagResolve);
    end
    tick();
    checks++;
    if (flagResolve !== 1'b1) begin failures++; $display("FAIL show_resolve_hold got=%b exp=1", flagResolve); end
    flag = 1'b0;
    tick();
    checks++;
    if (flagResolve !== 1'b0) begin failures++; $display("FAIL show_resolve_drop got=%b exp=0", flagResolve); end
    enter_digit(4'd6);
    checks++;
    if (inputCount !== 4'd1 || un0 !== 4'd6) begin
      failures++; $display("FAIL show_back_entry got=%0d/%0d exp=1/6", inputCount, un0);
    end
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic test_lock();
    flag = 1'b1; flagSelect = 1'b1;
    tick();
    checks++;
    if (lockoutInd !== 1'b1 || errorInd !== 1'b0) begin
      failures++; $display("FAIL lock_entry got=%b%b exp=10", lockoutInd, errorInd);
    end
    for (int i = 1; i < 10; i++) begin
      digit_valid = (i % 2) == 1;
      digit       = 4'd3;
      tick();
      checks++;
      if (lockoutInd !== 1'b1 || inputCount !== 4'd0) begin
        failures++; $display("FAIL lock_hold%0d got=%b/%0d exp=1/0", i, lockoutInd, inputCount);
      end
    end
    digit_valid = 1'b0;
    tick();
    checks++;
    if (lockoutInd !== 1'b0 || flagResolve !== 1'b1 || inputCount !== 4'd0) begin
      failures++; $display("FAIL lock_resolve got=%b%b/%0d exp=01/0", lockoutInd, flagResolve, inputCount);
    end
    tick();
    flag = 1'b0;
    tick();
    checks++;
    if (flagResolve !== 1'b0) begin failures++; $display("FAIL lock_resolve_drop got=%b exp=0", flagResolve); end
  endtask

  task automatic test_priority();
    enter_digit(4'd1);
    digit_valid = 1'b1; digit = 4'd5; clear = 1'b1;
    tick();
    digit_valid = 1'b0; clear = 1'b0;
    checks++;
    if (inputCount !== 4'd0 || un0 !== 4'd0) begin
      failures++; $display("FAIL prio_clear got=%0d/%0d exp=0/0", inputCount, un0);
    end
    enter_digit(4'd2);
    enter_digit(4'd3);
    resetCount = 1'b1; flag = 1'b1; flagSelect = 1'b0;
    tick();
    checks++;
    if (errorInd !== 1'b1 || lockoutInd !== 1'b0 || inputCount !== 4'd0) begin
      failures++; $display("FAIL prio_flag got=%b%b/%0d exp=10/0", errorInd, lockoutInd, inputCount);
    end
    for (int i = 0; i < 5; i++) tick();
    flag = 1'b0;
    tick();
    tick();
    enter_digit(4'd4);
    checks++;
    if (inputCount !== 4'd1 || un0 !== 4'd4) begin
      failures++; $display("FAIL prio_after got=%0d/%0d exp=1/4", inputCount, un0);
    end
    resetCount = 1'b0;
    tick();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic test_reset_mid_lock();
    flag = 1'b1; flagSelect = 1'b1;
    tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if (lockoutInd !== 1'b0) begin failures++; $display("FAIL midlock_abort got=%b exp=0", lockoutInd); end
    rst_n = 1'b1; flagSelect = 1'b0;
    tick();
    checks++;
    if (errorInd !== 1'b1 || lockoutInd !== 1'b0) begin
      failures++; $display("FAIL midlock_reenter got=%b%b exp=10", errorInd, lockoutInd);
    end
    flag = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (errorInd !== 1'b1) begin failures++; $display("FAIL early_drop_hold got=%b exp=1", errorInd); end
    tick();
    checks++;
    if (flagResolve !== 1'b1 || errorInd !== 1'b0) begin
      failures++; $display("FAIL early_drop_resolve got=%b%b exp=10", flagResolve, errorInd);
    end
    tick();
    checks++;
    if (flagResolve !== 1'b0) begin failures++; $display("FAIL early_drop_exit got=%b exp=0", flagResolve); end
  endtask

  initial begin
    rst_n = 1'b0; digit_valid = 1'b0; digit = '0; backspace = 1'b0; clear = 1'b0;
    resetCount = 1'b0; flag = 1'b0; flagSelect = 1'b0;
    #1;
    test_reset();
    test_fill();
    test_backspace();
    test_reset_count();
    test_show();
    test_lock();
    test_priority();
    test_reset_mid_lock();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
